// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 constants, special-operand codes and the normalize-stage record
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_W   = 8;
  localparam int FP_MANT_W  = 23;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  localparam logic [1:0] SP_NORM = 2'b00;
  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  // One beat after normalization: 24-bit significand plus guard/sticky,
  // signed unbiased-plus-bias exponent, and a flag for pre-shifted subnormals.
  typedef struct packed {
    logic                 sign;
    logic [1:0]           special;
    logic [FP_MANT_W:0]   sig;
    logic                 guard;
    logic                 sticky;
    logic                 tiny;
    logic signed [10:0]   e;
  } s1_t;

  // Signed infinity of the given sign.
  function automatic logic [31:0] fp_inf(input logic s);
    return {s, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_mul_normalize_if.sv
// rtl/fp_mul_normalize_if.sv - beat interface between mantissa multiplier, normalizer and consumer
interface fp_mul_normalize_if;

  logic        in_val;
  logic        in_ready;
  logic        sign;
  logic [8:0]  exp_sum;
  logic [47:0] mant_prod;
  logic [1:0]  special;

  logic [31:0] res;
  logic        out_val;
  logic        out_ready;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  modport slave (
    input  in_val, sign, exp_sum, mant_prod, special, out_ready,
    output in_ready, res, out_val, overflow, underflow, inexact
  );

  modport master (
    output in_val, sign, exp_sum, mant_prod, special, out_ready,
    input  in_ready, res, out_val, overflow, underflow, inexact
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of a 24-bit significand with guard/sticky
module fp_round_rne (
  input  logic [23:0] sig,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] sig_out,
  output logic        carry,
  output logic        inexact
);

  logic        up;
  logic [24:0] sum;

  // Increment on more-than-half, or exactly half with an odd LSB; renormalize on carry-out.
  always_comb begin
    up      = guard & (sticky | sig[0]);
    sum     = {1'b0, sig} + {24'd0, up};
    carry   = sum[24];
    sig_out = carry ? sum[24:1] : sum[23:0];
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_mul_normalize.sv
// rtl/fp_mul_normalize.sv - two-stage normalize/round of the FP multiply product (FP_MUL_SUBNORM_EN: gradual underflow)
module fp_mul_normalize
  import fp_pkg::*;
(
  input logic               clk,
  input logic               reset,
  fp_mul_normalize_if.slave bus
);

  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  s1_t         s1_q, s1_d;
  s1_t         s1_new;
  logic [31:0] res_q, res_d;
  logic        ov_q, ov_d;
  logic        uf_q, uf_d;
  logic        inx_q, inx_d;

  logic        adv1, adv2;

  logic               n_bit;
  logic [23:0]        sig_nrm;
  logic               guard_nrm;
  logic               sticky_nrm;
  logic signed [10:0] e_nrm;
`ifdef FP_MUL_SUBNORM_EN
  logic signed [10:0] sh_full;
  logic [4:0]         sh;
  logic [24:0]        x_ext;
  logic [24:0]        x_shr;
  logic               lost;
`endif

  logic [23:0]        r_sig;
  logic               r_carry;
  logic               r_inexact;
  logic signed [10:0] e_rnd;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv2 = !v2_q | bus.out_ready;
    adv1 = !v1_q | adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_val   = v2_q;
  assign bus.res       = res_q;
  assign bus.overflow  = ov_q;
  assign bus.underflow = uf_q;
  assign bus.inexact   = inx_q;

  // Stage 1: pick the leading one, split into significand/guard/sticky, unbias the exponent.
  always_comb begin
    n_bit      = bus.mant_prod[47];
    sig_nrm    = n_bit ? bus.mant_prod[47:24] : bus.mant_prod[46:23];
    guard_nrm  = n_bit ? bus.mant_prod[23] : bus.mant_prod[22];
    sticky_nrm = n_bit ? (|bus.mant_prod[22:0]) : (|bus.mant_prod[21:0]);
    e_nrm      = {2'b00, bus.exp_sum} - 11'(FP_BIAS) + 11'(n_bit);

    s1_new.sign    = bus.sign;
    s1_new.special = bus.special;
    s1_new.sig     = sig_nrm;
    s1_new.guard   = guard_nrm;
    s1_new.sticky  = sticky_nrm;
    s1_new.tiny    = 1'b0;
    s1_new.e       = e_nrm;

`ifdef FP_MUL_SUBNORM_EN
    // Denormalize so the LSB lands on 2^-149; beyond 25 places everything is sticky.
    sh_full = 11'sd1 - e_nrm;
    sh      = (sh_full > 11'sd25) ? 5'd25 : sh_full[4:0];
    x_ext   = {sig_nrm, guard_nrm};
    x_shr   = x_ext >> sh;
    lost    = |(x_ext & ~({25{1'b1}} << sh));
    if (e_nrm <= 11'sd0) begin
      s1_new.sig    = x_shr[24:1];
      s1_new.guard  = x_shr[0];
      s1_new.sticky = sticky_nrm | lost;
      s1_new.tiny   = 1'b1;
    end
`endif

    v1_d = adv1 ? bus.in_val : v1_q;
    s1_d = (adv1 && bus.in_val) ? s1_new : s1_q;
  end

  fp_round_rne u_round (
    .sig     (s1_q.sig),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .sig_out (r_sig),
    .carry   (r_carry),
    .inexact (r_inexact)
  );

  // Stage 2: apply rounding, range-check the exponent, let specials override everything.
  always_comb begin
    e_rnd = s1_q.e + 11'(r_carry);
    v2_d  = adv2 ? v1_q : v2_q;
    res_d = res_q;
    ov_d  = ov_q;
    uf_d  = uf_q;
    inx_d = inx_q;
    if (adv2 && v1_q) begin
      ov_d  = 1'b0;
      uf_d  = 1'b0;
      inx_d = 1'b0;
      case (s1_q.special)
        SP_ZERO: res_d = {s1_q.sign, 31'h0};
        SP_INF:  res_d = fp_inf(s1_q.sign);
        SP_NAN:  res_d = FP_QNAN;
        default: begin
          if (s1_q.tiny) begin
            // Rounding up into bit 23 turns the subnormal into the smallest normal.
            res_d = {s1_q.sign, 7'd0, r_sig};
            uf_d  = r_inexact;
            inx_d = r_inexact;
          end else if (e_rnd >= $signed(11'(FP_EXP_MAX))) begin
            res_d = fp_inf(s1_q.sign);
            ov_d  = 1'b1;
            inx_d = 1'b1;
          end else if (e_rnd <= 11'sd0) begin
            res_d = {s1_q.sign, 31'h0};
            uf_d  = 1'b1;
            inx_d = 1'b1;
          end else begin
            res_d = {s1_q.sign, e_rnd[7:0], r_sig[22:0]};
            inx_d = r_inexact;
          end
        end
      endcase
    end
  end

  // State registers; reset discards in-flight beats and clears the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= '0;
      res_q <= 32'h0;
      ov_q  <= 1'b0;
      uf_q  <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      s1_q  <= s1_d;
      res_q <= res_d;
      ov_q  <= ov_d;
      uf_q  <= uf_d;
      inx_q <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// tb/tb_fp_mul_normalize.sv - randomized and directed checks of fp_mul_normalize against a value-level model
module tb_fp_mul_normalize;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_normalize_if bus ();

  fp_mul_normalize dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [34:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Exact product = mp * 2^(es - 300); quantize to the binary32 grid with RNE.
  // Returns {overflow, underflow, inexact, res}.
  function automatic logic [34:0] model(input logic s, input logic [8:0] es,
                                        input logic [47:0] mp, input logic [1:0] sp);
    logic [255:0] w, kept, rem, half;
    int p, q, big_e, esi;
    logic up, inx;
    if (sp == 2'b01) return {3'b000, s, 31'h0};
    if (sp == 2'b10) return {3'b000, s, 8'hFF, 23'h0};
    if (sp == 2'b11) return {3'b000, 32'h7FC00000};
    esi = int'(es);
    p = mp[47] ? 47 : 46;
    q = p - 23;
`ifdef FP_MUL_SUBNORM_EN
    if (151 - esi > q) q = 151 - esi;
`endif
    w    = 256'(mp);
    kept = w >> q;
    rem  = w - (kept << q);
    half = 256'd1 << (q - 1);
    up   = (rem > half) || ((rem == half) && kept[0]);
    inx  = (rem != 0);
    kept = kept + 256'(up);
    if ((kept >> 24) != 0) begin
      kept = kept >> 1;
      q = q + 1;
    end
    if ((kept >> 23) != 0) big_e = q + esi - 150;
    else big_e = 0;
    if (big_e >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if ((kept >> 23) == 0) return {1'b0, inx, inx, s, 8'h00, kept[22:0]};
    if (big_e <= 0) return {3'b011, s, 31'h0};
    return {2'b00, inx, s, big_e[7:0], kept[22:0]};
  endfunction

  // One cycle: drive at negedge, then score the output beat and record the accepted input.
  task automatic drive(input logic v, input logic s, input logic [8:0] es, input logic [47:0] mp,
                       input logic [1:0] sp, input logic ordy, output logic acc, output logic popped);
    logic [34:0] e_item;
    @(negedge clk);
    bus.in_val    = v;
    bus.sign      = s;
    bus.exp_sum   = es;
    bus.mant_prod = mp;
    bus.special   = sp;
    bus.out_ready = ordy;
    #1;
    popped = 1'b0;
    if (bus.out_val && bus.out_ready) begin
      popped = 1'b1;
      if (sb_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e_item = sb_q.pop_front();
        chk("res", bus.res, e_item[31:0]);
        chk("flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(e_item[34:32]));
      end
    end
    acc = v && bus.in_ready;
    if (acc) sb_q.push_back(model(s, es, mp, sp));
  endtask

  task automatic dir(input string tag, input logic s, input logic [8:0] es, input logic [47:0] mp,
                     input logic [1:0] sp, input logic [31:0] er, input logic [2:0] ef);
    logic acc, pop;
    drive(1'b1, s, es, mp, sp, 1'b1, acc, pop);
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    drive(1'b0, s, es, mp, sp, 1'b1, acc, pop);
    chk({tag, "_lat1"}, 32'(bus.out_val), 32'd0);
    drive(1'b0, s, es, mp, sp, 1'b1, acc, pop);
    chk({tag, "_lat2"}, 32'(bus.out_val), 32'd1);
    chk({tag, "_res"}, bus.res, er);
    chk({tag, "_flg"}, 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(ef));
  endtask

  task automatic rand_beat(output logic s, output logic [8:0] es, output logic [47:0] mp,
                           output logic [1:0] sp);
    int k;
    s  = 1'($urandom);
    mp = {16'($urandom), $urandom};
    if ($urandom_range(1, 0) == 1) mp[47] = 1'b1;
    else begin
      mp[47] = 1'b0;
      mp[46] = 1'b1;
    end
    k = $urandom_range(3, 0);
    if (k == 0) mp[21:0] = '0;
    else if (k == 1) mp[22:0] = '0;
    k = $urandom_range(3, 0);
    if (k == 0) es = 9'($urandom_range(160, 90));
    else if (k == 1) es = 9'($urandom_range(390, 370));
    else es = 9'($urandom_range(510, 0));
    sp = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
  endtask

  initial begin
    logic acc, pop;
    logic s;
    logic [8:0] es;
    logic [47:0] mp;
    logic [1:0] sp;
    int guard_cnt;

    reset = 1'b1;
    bus.in_val = 1'b0; bus.sign = 1'b0; bus.exp_sum = '0;
    bus.mant_prod = '0; bus.special = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_res", bus.res, 32'h0);
    chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);

    dir("mul_1p5", 1'b0, 9'd254, 48'h9000_0000_0000, 2'b00, 32'h40100000, 3'b000);
    dir("rne_tie", 1'b0, 9'd254, 48'h4000_0040_0000, 2'b00, 32'h3F800000, 3'b001);
    dir("rne_up",  1'b0, 9'd254, 48'h4000_00C0_0000, 2'b00, 32'h3F800002, 3'b001);
    dir("ovf",     1'b1, 9'd400, 48'h8000_0000_0000, 2'b00, 32'hFF800000, 3'b101);
`ifdef FP_MUL_SUBNORM_EN
    dir("tiny",    1'b0, 9'd127, 48'h4000_0000_0000, 2'b00, 32'h00400000, 3'b000);
`else
    dir("tiny",    1'b0, 9'd127, 48'h4000_0000_0000, 2'b00, 32'h00000000, 3'b011);
`endif
    dir("sp_nan",  1'b1, 9'd254, 48'h9000_0000_0000, 2'b11, 32'h7FC00000, 3'b000);
    dir("sp_zero", 1'b1, 9'd254, 48'h9000_0000_0000, 2'b01, 32'h80000000, 3'b000);
    dir("sp_inf",  1'b0, 9'd10,  48'h4000_0000_0000, 2'b10, 32'h7F800000, 3'b000);

    // Backpressure: two beats fill the pipe, the third waits, output holds.
    drive(1'b1, 1'b0, 9'd254, 48'h9000_0000_0000, 2'b00, 1'b0, acc, pop);
    chk("bp_acc0", 32'(acc), 32'd1);
    drive(1'b1, 1'b1, 9'd200, 48'h4000_00C0_0000, 2'b00, 1'b0, acc, pop);
    chk("bp_acc1", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 9'd130, 48'hC123_4567_89AB, 2'b00, 1'b0, acc, pop);
      chk("bp_acc2_blocked", 32'(acc), 32'd0);
      chk("bp_out_val", 32'(bus.out_val), 32'd1);
      chk("bp_res_hold", bus.res, 32'h40100000);
    end
    drive(1'b1, 1'b0, 9'd130, 48'hC123_4567_89AB, 2'b00, 1'b1, acc, pop);
    chk("bp_rel_acc", 32'(acc), 32'd1);
    chk("bp_rel_pop0", 32'(pop), 32'd1);
    drive(1'b0, 1'b0, 9'd0, 48'h0, 2'b00, 1'b1, acc, pop);
    chk("bp_rel_pop1", 32'(pop), 32'd1);
    drive(1'b0, 1'b0, 9'd0, 48'h0, 2'b00, 1'b1, acc, pop);
    chk("bp_rel_pop2", 32'(pop), 32'd1);
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Reset with two beats in flight.
    drive(1'b1, 1'b0, 9'd254, 48'h9000_0000_0000, 2'b00, 1'b0, acc, pop);
    drive(1'b1, 1'b1, 9'd254, 48'h9000_0000_0000, 2'b00, 1'b0, acc, pop);
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.in_val = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_val", 32'(bus.out_val), 32'd0);
    chk("mid_rst_res", bus.res, 32'h0);
    sb_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_val2", 32'(bus.out_val), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      rand_beat(s, es, mp, sp);
      drive(($urandom_range(9, 0) < 7), s, es, mp, sp, ($urandom_range(9, 0) < 7), acc, pop);
    end
    guard_cnt = 0;
    while (sb_q.size() != 0 && guard_cnt < 40) begin
      drive(1'b0, 1'b0, 9'd0, 48'h0, 2'b00, 1'b1, acc, pop);
      guard_cnt++;
    end
    chk("final_drain", 32'(sb_q.size()), 32'd0);
    drive(1'b0, 1'b0, 9'd0, 48'h0, 2'b00, 1'b1, acc, pop);
    chk("final_idle", 32'(bus.out_val), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
